// File: rtl/riscv_cpu_pkg.sv
// Shared CPU types: pipeline bundles, funct3 codes, flags, branch selects.
// Memory-stage additions: mem_op_e, mem_state_e and lane helpers.
package riscv_cpu_pkg;

  localparam int XLEN         = 32;
  localparam int MEM_BE_WIDTH = 4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int CSR_ZERO  = 0;
  localparam int CSR_SIGN  = 1;
  localparam int CSR_WIDTH = 2;

  localparam logic [1:0] NO_BRANCH         = 2'b00;
  localparam logic [1:0] BRANCH_IF_EQUAL   = 2'b01;
  localparam logic [1:0] BRANCH_IF_EQUAL_N = 2'b10;
  localparam logic [1:0] BRANC_IF_SIGN     = 2'b11;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] data_b;
    logic [XLEN-1:0] branch_addr;
    logic [1:0]      branch_mux;
    logic [4:0]      rd;
    logic            reg_we;
  } id_stage_t;

  typedef struct packed {
    logic [XLEN-1:0]      alu_result;
    logic [CSR_WIDTH-1:0] alu_csr;
    id_stage_t            id_stage;
  } ex2mem_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      rd;
    logic            reg_we;
  } mem2wb_t;

  function automatic logic branch_eval(
    input logic [1:0]           mux,
    input logic [CSR_WIDTH-1:0] csr
  );
    logic t;
    t = 1'b0;
    case (mux)
      BRANCH_IF_EQUAL:   t = csr[CSR_ZERO];
      BRANCH_IF_EQUAL_N: t = !csr[CSR_ZERO];
      BRANC_IF_SIGN:     t = csr[CSR_SIGN];
      default:           t = 1'b0;
    endcase
    return t;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    return (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr != 2'b00);
  endfunction

  function automatic logic [MEM_BE_WIDTH-1:0] be_for(
    input logic       store,
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [MEM_BE_WIDTH-1:0] be;
    be = 4'b1111;
    if (store) begin
      case (size)
        2'b00:   be = 4'b0001 << addr;
        2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [XLEN-1:0] lane_data(
    input logic [1:0]      size,
    input logic [XLEN-1:0] data
  );
    logic [XLEN-1:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/riscv_mem_stage_load_extend.sv
// Load-data lane select and sign/zero extension.
// Pure combinational; funct3[2] selects zero-extension.
module riscv_load_extend (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    b       = shifted[7:0];
    h       = addr[1] ? rdata[31:16] : rdata[15:0];
    sx      = ~funct3[2];
    case (funct3[1:0])
      2'b00:   value = {{24{sx & b[7]}}, b};
      2'b01:   value = {{16{sx & h[15]}}, h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_mem_stage.sv
// MEM stage: one data-memory transaction per instruction over req/gnt/rvalid,
// branch resolution from ALU flags, registered hand-off to WB.
module riscv_mem_stage
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ex_valid_i,
  output logic                    ex_ready_o,
  input  ex2mem_t                 ex2mem_i,
  input  logic [1:0]              mem_op_i,
  input  logic [2:0]              mem_funct3_i,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [DATA_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [MEM_BE_WIDTH-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  output logic                    wb_valid_o,
  output mem2wb_t                 mem2wb_o,
  output logic                    branch_taken_o,
  output logic [DATA_WIDTH-1:0]   branch_target_o,
  output logic                    misaligned_o
);

  mem_state_e state_q, state_d;

  logic [1:0]            op_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] datab_q;
  logic [DATA_WIDTH-1:0] baddr_q;
  logic [4:0]            rd_q;
  logic                  we_q;
  logic                  br_q;

  logic                  accept;
  logic                  is_mem;
  logic                  mis;
  logic                  go_mem;
  logic                  fast;
  logic                  done;
  logic                  is_ld;
  logic                  br_in;
  logic [DATA_WIDTH-1:0] ext;

  assign ex_ready_o = (state_q == IDLE);
  assign accept     = ex_valid_i & ex_ready_o;
  assign is_mem     = (mem_op_i == MEM_LOAD) ||
                      (mem_op_i == MEM_STORE);
  assign mis        = is_mem & is_misaligned(
                        mem_funct3_i[1:0],
                        ex2mem_i.alu_result[1:0]);
  assign go_mem     = accept & is_mem & ~mis;
  assign fast       = accept & ~go_mem;
  assign done       = (state_q == RESP) & data_rvalid_i;
  assign is_ld      = (op_q == MEM_LOAD);
  assign br_in      = branch_eval(
                        ex2mem_i.id_stage.branch_mux,
                        ex2mem_i.alu_csr);

  // Bus fields come straight from the holding register so they stay
  // frozen while a request waits for its grant.
  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign data_we_o    = (op_q == MEM_STORE);
  assign data_be_o    = (is_ld || data_we_o) ?
                        be_for(data_we_o, f3_q[1:0], addr_q[1:0]) :
                        '0;
  assign data_wdata_o = lane_data(f3_q[1:0], datab_q);

  riscv_load_extend u_load_extend (
    .funct3 (f3_q),
    .addr   (addr_q[1:0]),
    .rdata  (data_rdata_i),
    .value  (ext)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go_mem) state_d = REQ;
      REQ:     if (data_gnt_i) state_d = RESP;
      RESP:    if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= MEM_NONE;
      f3_q    <= '0;
      addr_q  <= '0;
      datab_q <= '0;
      baddr_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= mem_op_i;
        f3_q    <= mem_funct3_i;
        addr_q  <= ex2mem_i.alu_result;
        datab_q <= ex2mem_i.id_stage.data_b;
        baddr_q <= ex2mem_i.id_stage.branch_addr;
        rd_q    <= ex2mem_i.id_stage.rd;
        we_q    <= ex2mem_i.id_stage.reg_we;
        br_q    <= br_in;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o      <= 1'b0;
      mem2wb_o        <= '0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
      misaligned_o    <= 1'b0;
    end else begin
      wb_valid_o     <= fast | done;
      misaligned_o   <= fast & mis;
      branch_taken_o <= 1'b0;
      if (fast) begin
        mem2wb_o.alu_result <= ex2mem_i.alu_result;
        mem2wb_o.mem_data   <= '0;
        mem2wb_o.rd         <= ex2mem_i.id_stage.rd;
        mem2wb_o.reg_we     <= ex2mem_i.id_stage.reg_we & ~mis;
        branch_taken_o      <= br_in;
        branch_target_o     <= ex2mem_i.id_stage.branch_addr;
      end else if (done) begin
        mem2wb_o.alu_result <= addr_q;
        mem2wb_o.mem_data   <= is_ld ? ext : '0;
        mem2wb_o.rd         <= rd_q;
        mem2wb_o.reg_we     <= is_ld & we_q;
        branch_taken_o      <= br_q;
        branch_target_o     <= baddr_q;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Scoreboard bench for riscv_mem_stage: directed vectors push expected WB
// records, a negedge monitor pops and compares on each wb_valid_o.
module tb_riscv_mem_stage;
  import riscv_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  ex2mem_t     ex2mem = '0;
  logic [1:0]  mem_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        req;
  logic        gnt = 1'b0;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        wb_valid;
  mem2wb_t     mem2wb;
  logic        bt;
  logic [31:0] btgt;
  logic        mis;

  always #5 clk = ~clk;

  riscv_mem_stage #(.DATA_WIDTH(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ex_valid_i      (ex_valid),
    .ex_ready_o      (ex_ready),
    .ex2mem_i        (ex2mem),
    .mem_op_i        (mem_op),
    .mem_funct3_i    (funct3),
    .data_req_o      (req),
    .data_gnt_i      (gnt),
    .data_addr_o     (addr),
    .data_we_o       (we),
    .data_be_o       (be),
    .data_wdata_o    (wdata),
    .data_rvalid_i   (rvalid),
    .data_rdata_i    (rdata),
    .wb_valid_o      (wb_valid),
    .mem2wb_o        (mem2wb),
    .branch_taken_o  (bt),
    .branch_target_o (btgt),
    .misaligned_o    (mis)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] md;
    logic        chk_md;
    logic        we;
    logic [4:0]  rd;
    logic        bt;
    logic [31:0] tgt;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check32(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name,
                        input logic act,
                        input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic [31:0] a, input logic [31:0] md,
                           input logic chk, input logic w,
                           input logic [4:0] rd, input logic b,
                           input logic [31:0] t, input logic m);
    exp_t e;
    e.alu = a; e.md = md; e.chk_md = chk; e.we = w;
    e.rd = rd; e.bt = b; e.tgt = t; e.mis = m;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got alu %h expected no completion",
                 mem2wb.alu_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check32("wb_alu", mem2wb.alu_result, e.alu);
        if (e.chk_md) check32("wb_mem_data", mem2wb.mem_data, e.md);
        check1("wb_reg_we", mem2wb.reg_we, e.we);
        check32("wb_rd", 32'(mem2wb.rd), 32'(e.rd));
        check1("wb_branch", bt, e.bt);
        check32("wb_target", btgt, e.tgt);
        check1("wb_misaligned", mis, e.mis);
      end
    end
  end

  task automatic send(input logic [31:0] alu, input logic [1:0] csr,
                      input logic [31:0] datab, input logic [31:0] baddr,
                      input logic [1:0] bmux, input logic [4:0] rd,
                      input logic w, input logic [1:0] op,
                      input logic [2:0] f3);
    ex2mem.alu_result           = alu;
    ex2mem.alu_csr              = csr;
    ex2mem.id_stage.data_b      = datab;
    ex2mem.id_stage.branch_addr = baddr;
    ex2mem.id_stage.branch_mux  = bmux;
    ex2mem.id_stage.rd          = rd;
    ex2mem.id_stage.reg_we      = w;
    mem_op   = op;
    funct3   = f3;
    ex_valid = 1'b1;
    for (int i = 0; i < 20 && !ex_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!ex_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ex_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Entered one tick after the accepting edge (state REQ).
  task automatic mem_respond(input int gdly, input int rdly,
                             input logic [31:0] rd_word,
                             input logic [31:0] e_addr,
                             input logic [3:0] e_be,
                             input logic e_we,
                             input logic [31:0] e_wd,
                             input logic chk_wd,
                             output int reqc);
    reqc = 0;
    for (int i = 0; i <= gdly; i++) begin
      check1("req_high", req, 1'b1);
      check32("req_addr", addr, e_addr);
      check32("req_be", 32'(be), 32'(e_be));
      check1("req_we", we, e_we);
      if (chk_wd) check32("req_wdata", wdata, e_wd);
      check1("req_not_ready", ex_ready, 1'b0);
      check1("req_no_wb", wb_valid, 1'b0);
      if (req) reqc++;
      if (i == gdly) gnt = 1'b1;
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    for (int j = 1; j < rdly; j++) begin
      check1("resp_req_low", req, 1'b0);
      check1("resp_not_ready", ex_ready, 1'b0);
      check1("resp_no_wb", wb_valid, 1'b0);
      @(posedge clk); #1;
    end
    rvalid = 1'b1;
    rdata  = rd_word;
    @(posedge clk); #1;
    rvalid = 1'b0;
    check1("done_wb_valid", wb_valid, 1'b1);
    check1("done_ready", ex_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_ready", ex_ready, 1'b1);
    check1("rst_req", req, 1'b0);
    check1("rst_we", we, 1'b0);
    check32("rst_be", 32'(be), 32'd0);
    check32("rst_addr", addr, 32'd0);
    check32("rst_wdata", wdata, 32'd0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check1("rst_branch", bt, 1'b0);
    check32("rst_target", btgt, 32'd0);
    check1("rst_mis", mis, 1'b0);
    check32("rst_wb_alu", mem2wb.alu_result, 32'd0);
    check1("rst_wb_reg_we", mem2wb.reg_we, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three ALU ops back-to-back
    for (int k = 0; k < 3; k++) begin
      expect_wb(32'h1234 + 32'(k * 4), 32'h0, 1'b1, 1'b1,
                5'(k + 1), 1'b0, 32'h0, 1'b0);
      send(32'h1234 + 32'(k * 4), 2'b00, 32'h0, 32'h0, NO_BRANCH,
           5'(k + 1), 1'b1, MEM_NONE, 3'b000);
      check1("b2b_wb_valid", wb_valid, 1'b1);
    end
    idle();
    check1("b2b_wb_drop", wb_valid, 1'b0);

    expect_wb(32'h103, 32'hFFFF_FF80, 1'b1, 1'b1, 5'd5,
              1'b0, 32'h0, 1'b0);
    send(32'h103, 2'b00, 32'h0, 32'h0, NO_BRANCH, 5'd5, 1'b1,
         MEM_LOAD, LB);
    mem_respond(0, 1, 32'h80FF_7F01, 32'h100, 4'b1111, 1'b0,
                32'h0, 1'b0, rc);

    expect_wb(32'h103, 32'h0000_0080, 1'b1, 1'b1, 5'd6,
              1'b0, 32'h0, 1'b0);
    send(32'h103, 2'b00, 32'h0, 32'h0, NO_BRANCH, 5'd6, 1'b1,
         MEM_LOAD, LBU);
    mem_respond(0, 1, 32'h80FF_7F01, 32'h100, 4'b1111, 1'b0,
                32'h0, 1'b0, rc);

    expect_wb(32'h302, 32'hFFFF_8001, 1'b1, 1'b1, 5'd8,
              1'b0, 32'h0, 1'b0);
    send(32'h302, 2'b00, 32'h0, 32'h0, NO_BRANCH, 5'd8, 1'b1,
         MEM_LOAD, LH);
    mem_respond(0, 1, 32'h8001_1234, 32'h300, 4'b1111, 1'b0,
                32'h0, 1'b0, rc);

    expect_wb(32'h202, 32'h0, 1'b0, 1'b0, 5'd9, 1'b0, 32'h0, 1'b0);
    send(32'h202, 2'b00, 32'hDEAD_BEEF, 32'h0, NO_BRANCH, 5'd9, 1'b1,
         MEM_STORE, SH);
    mem_respond(0, 1, 32'h0, 32'h200, 4'b1100, 1'b1,
                32'hBEEF_BEEF, 1'b1, rc);

    expect_wb(32'h101, 32'h0, 1'b0, 1'b0, 5'd10, 1'b0, 32'h0, 1'b0);
    send(32'h101, 2'b00, 32'h1234_56A5, 32'h0, NO_BRANCH, 5'd10, 1'b1,
         MEM_STORE, SB);
    mem_respond(0, 1, 32'h0, 32'h100, 4'b0010, 1'b1,
                32'hA5A5_A5A5, 1'b1, rc);

    // gnt late by 3, rvalid 2 after gnt, sign branch rides along
    expect_wb(32'h300, 32'hCAFE_F00D, 1'b1, 1'b1, 5'd11,
              1'b1, 32'h480, 1'b0);
    send(32'h300, 2'b10, 32'h0, 32'h480, BRANC_IF_SIGN, 5'd11, 1'b1,
         MEM_LOAD, LW);
    mem_respond(3, 2, 32'hCAFE_F00D, 32'h300, 4'b1111, 1'b0,
                32'h0, 1'b0, rc);
    check32("gnt_delay_req_cycles", 32'(rc), 32'd4);
    idle();
    check1("gnt_delay_single_wb", wb_valid, 1'b0);

    expect_wb(32'h301, 32'h0, 1'b1, 1'b0, 5'd12, 1'b0, 32'h0, 1'b1);
    send(32'h301, 2'b00, 32'h0, 32'h0, NO_BRANCH, 5'd12, 1'b1,
         MEM_LOAD, LW);
    check1("mis_no_req", req, 1'b0);
    check1("mis_flag", mis, 1'b1);
    check1("mis_wb_valid", wb_valid, 1'b1);
    idle();
    check1("mis_flag_drop", mis, 1'b0);

    expect_wb(32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h400, 1'b0);
    send(32'h0, 2'b00, 32'h0, 32'h400, BRANCH_IF_EQUAL_N, 5'd0, 1'b0,
         MEM_NONE, 3'b000);
    check1("bne_taken", bt, 1'b1);
    check32("bne_target", btgt, 32'h400);
    expect_wb(32'h4, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h440, 1'b0);
    send(32'h4, 2'b00, 32'h0, 32'h440, BRANCH_IF_EQUAL, 5'd0, 1'b0,
         MEM_NONE, 3'b000);
    check1("beq_not_taken", bt, 1'b0);
    idle();
    check1("branch_drop", bt, 1'b0);

    // reset while waiting for rvalid; late rvalid must be ignored
    send(32'h500, 2'b00, 32'h0, 32'h0, NO_BRANCH, 5'd13, 1'b1,
         MEM_LOAD, LW);
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    check1("resp_before_rst", ex_ready, 1'b0);
    rst_n = 1'b0;
    #2;
    check1("rst_async_ready", ex_ready, 1'b1);
    check1("rst_async_req", req, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'h1111_2222;
    @(posedge clk); #1;
    rvalid = 1'b0;
    check1("stray_rvalid_no_wb", wb_valid, 1'b0);
    check1("stray_rvalid_ready", ex_ready, 1'b1);
    check1("stray_rvalid_req", req, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
